alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 161 ++++++++++++++++
 tb/tb_alu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle logic/arith/shift ops and an iterative shift-add
// multiplier, behind a one-entry registered output stage with valid/ready flow control.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] first_i,
  input  logic [WIDTH-1:0] second_i,
  input  logic [3:0]       opcode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             illegal_o,
  output logic             dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_NAND = 4'd0;
  localparam logic [3:0] OP_XOR  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ASR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_ULT  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic             accept, is_mul, mul_done, sh_big;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

  // Handshake: an input op transfers on a rising edge where valid_i && ready_o;
  // a result transfers on a rising edge where valid_o && ready_i. valid_o never
  // drops and result/flags never change until the result has transferred.
  assign ready_o     = rst_ni && (state_q == ST_IDLE) && (!valid_o || ready_i);
  assign accept      = valid_i && ready_o;
  assign is_mul      = (opcode_i == OP_MUL);
  assign mul_done    = (state_q == ST_MUL) && (cnt_q == CW'(WIDTH - 1));
  assign acc_nxt     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign dbg_state_o = (state_q == ST_MUL);

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    add_full = {1'b0, first_i} + {1'b0, second_i};
    sub_full = {1'b0, first_i} - {1'b0, second_i};
    // The whole second operand is the shift distance, not just its low bits.
    sh_big   = (32'(second_i) >= WIDTH);
    case (opcode_i)
      OP_NAND: alu_res = ~(first_i & second_i);
      OP_XOR:  alu_res = first_i ^ second_i;
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (first_i[WIDTH-1] == second_i[WIDTH-1]) &&
                  (add_full[WIDTH-1] != first_i[WIDTH-1]);
      end
      OP_ASR:  alu_res = sh_big ? {WIDTH{first_i[WIDTH-1]}}
                                : ($signed(first_i) >>> second_i);
      OP_OR:   alu_res = first_i | second_i;
      OP_SHL:  alu_res = sh_big ? '0 : (first_i << second_i);
      OP_NOT:  alu_res = ~first_i;
      OP_ULT:  alu_res = {{(WIDTH-1){1'b0}}, (first_i < second_i)};
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (first_i[WIDTH-1] != second_i[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != first_i[WIDTH-1]);
      end
      OP_LSR:  alu_res = sh_big ? '0 : (first_i >> second_i);
      OP_MUL:  alu_res = '0;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(first_i) < $signed(second_i))};
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_done)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Multiplier consumes one multiplier bit per cycle, LSB first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, first_i};
      mplier_q <= second_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == ST_MUL) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= mul_done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b0;
      carry_o   <= 1'b0;
      ovf_o     <= 1'b0;
      illegal_o <= 1'b0;
    end else if (accept && !is_mul) begin
      valid_o   <= 1'b1;
      result_o  <= alu_res;
      zero_o    <= (alu_res == '0);
      carry_o   <= alu_c;
      ovf_o     <= alu_v;
      illegal_o <= alu_ill;
    end else if (accept) begin
      valid_o   <= 1'b0;
    end else if (mul_done) begin
      valid_o   <= 1'b1;
      result_o  <= acc_nxt[WIDTH-1:0];
      zero_o    <= (acc_nxt[WIDTH-1:0] == '0);
      carry_o   <= 1'b0;
      ovf_o     <= |acc_nxt[2*WIDTH-1:WIDTH];
      illegal_o <= 1'b0;
    end else if (ready_i) begin
      valid_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): scenario tasks drive ops, a scoreboard queue
// holds expected {illegal, ovf, carry, zero, result} for each accepted op.
module tb_alu_pipe;

  localparam int W = 8;

  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ASR = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] first_i;
  logic [W-1:0] second_i;
  logic [3:0]   opcode_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] result_o;
  logic         zero_o, carry_o, ovf_o, illegal_o;
  logic         dbg_state_o;

  logic [W+3:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_hs   = 0;
  bit bp_en  = 1'b0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .first_i(first_i), .second_i(second_i), .opcode_i(opcode_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .carry_o(carry_o), .ovf_o(ovf_o), .illegal_o(illegal_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model written with plain int arithmetic.
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int ua, ub, sa, sb, r;
    logic c, v, il;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      4'd0:  r = ~(ua & ub);
      4'd1:  r = ua ^ ub;
      4'd2:  begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd3:  r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> ub);
      4'd4:  r = ua | ub;
      4'd5:  r = (ub >= 8) ? 0 : (ua << ub);
      4'd6:  r = ~ua;
      4'd7:  r = (ua < ub) ? 1 : 0;
      4'd8:  begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd9:  r = (ub >= 8) ? 0 : (ua >> ub);
      4'd10: begin r = ua * ub; v = (r > 255); end
      4'd11: r = (sa < sb) ? 1 : 0;
      default: il = 1'b1;
    endcase
    r = r & 255;
    return {il, v, c, (r == 0), r[7:0]};
  endfunction

  // Scoreboard: compare every result that transfers (valid_o && ready_i).
  always @(negedge clk_i) begin
    logic [W+3:0] exp, got;
    #1;
    if (rst_ni === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      n_hs++;
      n_cmp++;
      got = {illegal_o, ovf_o, carry_o, zero_o, result_o};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got=%h required=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_result got=%h required=%h", got, exp);
        end
      end
    end
  end

  always @(negedge clk_i) if (bp_en) ready_i = 1'($urandom_range(0, 1));

  // Called and returns at a falling edge; the op is accepted at the rising edge in between.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit push, output int waits);
    waits = 0;
    opcode_i = op; first_i = a; second_i = b; valid_i = 1'b1;
    #1;
    while (ready_o !== 1'b1 && waits < 100) begin
      @(negedge clk_i); #1; waits++;
    end
    if (ready_o !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout got=ready_o %b required=1 op=%0d", ready_o, op);
    end else if (push) begin
      exp_q.push_back(model(op, a, b));
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    opcode_i = '0; first_i = '0; second_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++;
    if ({valid_o, result_o, zero_o, carry_o, ovf_o, illegal_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b required=0",
               {valid_o, result_o, zero_o, carry_o, ovf_o, illegal_o});
    end
    n_cmp++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b required=0", ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b required=1", ready_o); end
    @(negedge clk_i);
  endtask

  task automatic test_add_sub();
    int w;
    ready_i = 1'b1;
    send(OP_ADD, 8'hFF, 8'h01, 1'b1, w);
    #1;
    n_cmp++;
    if ({valid_o, result_o, zero_o, carry_o, ovf_o} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_latency1 got=%b required=%b", {valid_o, result_o, zero_o, carry_o, ovf_o},
               {1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk_i);
    send(OP_SUB, 8'h80, 8'h01, 1'b1, w);
    send(OP_SUB, 8'h01, 8'h02, 1'b1, w);
    @(negedge clk_i);
  endtask

  task automatic test_mul();
    int w, lat, low;
    ready_i = 1'b1;
    send(OP_MUL, 8'h10, 8'h11, 1'b1, w);
    lat = 0; low = 0;
    #1;
    n_cmp++;
    if (dbg_state_o !== 1'b1) begin n_fail++; $display("FAIL mul_state got=%b required=1", dbg_state_o); end
    while (valid_o !== 1'b1 && lat < 40) begin
      if (ready_o === 1'b0) low++;
      @(negedge clk_i); #1; lat++;
    end
    n_cmp++;
    if (lat !== 8) begin n_fail++; $display("FAIL mul_latency got=%0d required=8", lat); end
    n_cmp++;
    if (low !== 8) begin n_fail++; $display("FAIL mul_ready_low got=%0d required=8", low); end
    @(negedge clk_i);
    send(OP_MUL, 8'h0F, 8'h03, 1'b1, w);
  endtask

  task automatic test_shifts();
    int w;
    ready_i = 1'b1;
    send(OP_ASR, 8'h80, 8'd9, 1'b1, w);
    send(OP_SHL, 8'h01, 8'd8, 1'b1, w);
    send(OP_LSR, 8'h80, 8'd7, 1'b1, w);
    send(4'd13, 8'h5A, 8'h33, 1'b1, w);
    #1;
    n_cmp++;
    if ({valid_o, result_o, illegal_o, zero_o} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_op got=%b required=%b", {valid_o, result_o, illegal_o, zero_o},
               {1'b1, 8'h00, 1'b1, 1'b1});
    end
    @(negedge clk_i);
  endtask

  task automatic test_hold();
    logic [W+3:0] exp;
    int w;
    ready_i = 1'b0;
    exp = model(OP_XOR, 8'hA5, 8'h3C);
    send(OP_XOR, 8'hA5, 8'h3C, 1'b1, w);
    opcode_i = OP_ADD; first_i = 8'h02; second_i = 8'h03; valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (valid_o !== 1'b1 || {illegal_o, ovf_o, carry_o, zero_o, result_o} !== exp) begin
        n_fail++;
        $display("FAIL hold_stable got=%b/%h required=1/%h", valid_o,
                 {illegal_o, ovf_o, carry_o, zero_o, result_o}, exp);
      end
      n_cmp++;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_ready got=%b required=0", ready_o); end
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    send(OP_ADD, 8'h02, 8'h03, 1'b1, w);
    n_cmp++;
    if (w !== 0) begin n_fail++; $display("FAIL hold_release_wait got=%0d required=0", w); end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    int w, hs0, t0;
    logic [3:0] op;
    ready_i = 1'b1;
    hs0 = n_hs;
    t0 = $time;
    for (int k = 0; k < 8; k++) begin
      op = 4'($urandom_range(0, 15));
      if (op == OP_MUL) op = OP_XOR;
      send(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 10)), 1'b1, w);
      n_cmp++;
      if (w !== 0) begin n_fail++; $display("FAIL b2b_wait op%0d got=%0d required=0", k, w); end
    end
    n_cmp++;
    if (($time - t0) !== 80) begin n_fail++; $display("FAIL b2b_time got=%0d required=80", $time - t0); end
    #2;
    n_cmp++;
    if (n_hs - hs0 !== 8) begin n_fail++; $display("FAIL b2b_results got=%0d required=8", n_hs - hs0); end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_mul();
    int w;
    bit seen;
    ready_i = 1'b1;
    send(OP_ADD, 8'h02, 8'h03, 1'b1, w);
    send(OP_MUL, 8'h10, 8'h11, 1'b0, w);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({valid_o, result_o, zero_o, carry_o, ovf_o, illegal_o, ready_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%b required=0",
               {valid_o, result_o, zero_o, carry_o, ovf_o, illegal_o, ready_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk_i);
    end
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL mul_discarded got=valid required=no_valid"); end
    send(OP_ADD, 8'h02, 8'h03, 1'b1, w);
    #1;
    n_cmp++;
    if ({valid_o, result_o} !== {1'b1, 8'h05}) begin
      n_fail++;
      $display("FAIL post_reset_add got=%b/%h required=1/05", valid_o, result_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_random();
    int w, g;
    logic [W-1:0] b;
    bp_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), b, 1'b1, w);
    end
    bp_en = 1'b0;
    ready_i = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin @(negedge clk_i); g++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_shifts();
    test_hold();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
